// File: rtl/riscv_pkg.sv
// Shared rv32i pipeline types: result select, load funct3 codes
// and the MEM/WB bundle carried into the writeback stage.
package riscv_pkg;

    localparam int DATA_W = 32;
    localparam int RADR_W = 5;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10
    } result_src_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic [1:0]        result_src;
        logic [2:0]        funct3;
        logic [RADR_W-1:0] rd;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] read_data;
        logic [DATA_W-1:0] pc_plus4;
    } mem_wb_t;

endpackage

// File: rtl/load_ext.sv
// Load data alignment and sign/zero extension for rv32i loads.
// Halfword offset[0] is ignored; misalignment is trapped upstream.
module load_ext
    import riscv_pkg::*;
(
    input  logic [2:0]        funct3_i,
    input  logic [1:0]        offset_i,
    input  logic [DATA_W-1:0] word_i,
    output logic [DATA_W-1:0] ext_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // pick the addressed byte and halfword out of the raw word
    always_comb begin
        byte_v = word_i[7:0];
        case (offset_i)
            2'd0:    byte_v = word_i[7:0];
            2'd1:    byte_v = word_i[15:8];
            2'd2:    byte_v = word_i[23:16];
            default: byte_v = word_i[31:24];
        endcase
        half_v = offset_i[1] ? word_i[31:16] : word_i[15:0];
    end

    // extend according to load width and signedness
    always_comb begin
        ext_o = '0;
        case (funct3_i)
            F3_LB:   ext_o = {{24{byte_v[7]}}, byte_v};
            F3_LH:   ext_o = {{16{half_v[15]}}, half_v};
            F3_LW:   ext_o = word_i;
            F3_LBU:  ext_o = {24'd0, byte_v};
            F3_LHU:  ext_o = {16'd0, half_v};
            default: ext_o = '0;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, result select, regfile write port.
// Optional retired-instruction counter enabled by WB_INSTRET_EN.
module wb_stage
    import riscv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_m,
    input  logic              stall_w,
    input  logic              flush_w,
    input  logic              reg_write_m,
    input  logic [1:0]        result_src_m,
    input  logic [2:0]        funct3_m,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [XLEN-1:0]   alu_result_m,
    input  logic [XLEN-1:0]   read_data_m,
    input  logic [XLEN-1:0]   pc_plus4_m,
    output logic              we3,
    output logic [REG_AW-1:0] a3,
    output logic [XLEN-1:0]   wd3,
    output logic              reg_write_w,
    output logic [REG_AW-1:0] rd_w,
    output logic [XLEN-1:0]   result_w
`ifdef WB_INSTRET_EN
    ,
    output logic [63:0]       instret
`endif
);

    mem_wb_t           mem_wb_q;
    mem_wb_t           mem_wb_d;
    logic [XLEN-1:0]   load_val;
    logic [XLEN-1:0]   result;
    logic              we;

    // next MEM/WB contents: flush beats stall beats capture
    always_comb begin
        mem_wb_d = mem_wb_q;
        if (flush_w) begin
            mem_wb_d.valid     = 1'b0;
            mem_wb_d.reg_write = 1'b0;
        end else if (!stall_w) begin
            mem_wb_d.valid      = valid_m;
            mem_wb_d.reg_write  = reg_write_m & valid_m;
            mem_wb_d.result_src = result_src_m;
            mem_wb_d.funct3     = funct3_m;
            mem_wb_d.rd         = rd_m;
            mem_wb_d.alu_result = alu_result_m;
            mem_wb_d.read_data  = read_data_m;
            mem_wb_d.pc_plus4   = pc_plus4_m;
        end
    end

    // MEM/WB pipeline register with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_wb_q <= '0;
        end else begin
            mem_wb_q <= mem_wb_d;
        end
    end

    load_ext u_load_ext (
        .funct3_i (mem_wb_q.funct3),
        .offset_i (mem_wb_q.alu_result[1:0]),
        .word_i   (mem_wb_q.read_data),
        .ext_o    (load_val)
    );

    // final result select from registered fields
    always_comb begin
        result = '0;
        case (mem_wb_q.result_src)
            RES_ALU:  result = mem_wb_q.alu_result;
            RES_LOAD: result = load_val;
            RES_PC4:  result = mem_wb_q.pc_plus4;
            default:  result = '0;
        endcase
    end

    // x0 is never written; a stalled write repeats harmlessly
    assign we = mem_wb_q.valid & mem_wb_q.reg_write
              & (mem_wb_q.rd != '0);

    assign we3         = we;
    assign a3          = mem_wb_q.rd;
    assign wd3         = result;
    assign reg_write_w = we;
    assign rd_w        = mem_wb_q.rd;
    assign result_w    = result;

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q;
    logic [63:0] instret_d;

    // count an instruction when it leaves WB unstalled and unflushed
    always_comb begin
        instret_d = instret_q;
        if (mem_wb_q.valid && !stall_w && !flush_w) begin
            instret_d = instret_q + 64'd1;
        end
    end

    // retired-instruction counter, wraps naturally at 2^64
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;
`endif

endmodule
